// File: rtl/csr_trap_unit_if.sv
// Core-side bundle of the machine-mode CSR/trap unit: CSR access, trap inputs and PC redirect.
// The core drives through master; the trap unit connects through slave.
interface csr_trap_unit_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] pc;
  logic            inst_valid;
  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_tval;
  logic            is_mret;
  logic            is_wfi;
  logic            trap_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;

  modport master (
    output csr_addr, csr_op, csr_wdata, pc, inst_valid, exc_valid, exc_cause, exc_tval,
           is_mret, is_wfi,
    input  csr_rdata, trap_taken, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, pc, inst_valid, exc_valid, exc_cause, exc_tval,
           is_mret, is_wfi,
    output csr_rdata, trap_taken, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, trap/mret redirect and WFI stall for the single-cycle RV32 core.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit #(
  parameter int          XLEN         = 32,
  parameter int          NUM_PLAT_IRQ = 4,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  csr_trap_unit_if.slave          bus,
  input  logic                    irq_ext_i,
  input  logic                    irq_timer_i,
  input  logic                    irq_soft_i,
  input  logic [NUM_PLAT_IRQ-1:0] irq_plat_i
);
  localparam int NL = NUM_PLAT_IRQ + 3;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MIE = 12'h304, A_MTVEC = 12'h305;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
  localparam logic [11:0] A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82;
  localparam logic [XLEN-1:0] MIE_MASK =
    ((((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16) | 32'h0000_0888);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [NL-1:0]   sync_q [SYNC_STAGES];
  logic [NL-1:0]   irq_line_s;
  logic [XLEN-1:0] mip_s, pend_s, rd_val_s, csr_new_s, trap_tval_s, mtvec_base_s;
  logic [63:0]     mcycle_s, minstret_s;
  logic            impl_s, op_s, act_s, illegal_s, exc_s, irq_s, trap_s, mret_s, csr_we_s;
  logic            trap_irq_s;
  logic [4:0]      trap_cause_s;

  // Highest-priority pending interrupt: MEI > MSI > MTI > lowest platform line.
  function automatic logic [4:0] irq_cause(input logic [XLEN-1:0] p);
    logic [4:0] c;
    c = 5'd0;
    for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
      if (p[16+i]) c = 5'(16 + i);
    end
    if (p[7])  c = 5'd7;
    if (p[3])  c = 5'd3;
    if (p[11]) c = 5'd11;
    return c;
  endfunction

  // Interrupt line synchronisers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {irq_plat_i, irq_ext_i, irq_timer_i, irq_soft_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_line_s = sync_q[SYNC_STAGES-1];

  // Pending view and read mux.
  always_comb begin
    mip_s = '0;
    mip_s[3]  = irq_line_s[0];
    mip_s[7]  = irq_line_s[1];
    mip_s[11] = irq_line_s[2];
    mip_s[16 +: NUM_PLAT_IRQ] = irq_line_s[NL-1:3];
    pend_s = mip_s & mie_q;
    impl_s = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS:   rd_val_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:       rd_val_s = mie_q;
      A_MTVEC:     rd_val_s = mtvec_q;
      A_MEPC:      rd_val_s = mepc_q;
      A_MCAUSE:    rd_val_s = mcause_q;
      A_MTVAL:     rd_val_s = mtval_q;
      A_MIP:       rd_val_s = mip_s;
      A_MCYCLE:    rd_val_s = mcycle_s[31:0];
      A_MCYCLEH:   rd_val_s = mcycle_s[63:32];
      A_MINSTRET:  rd_val_s = minstret_s[31:0];
      A_MINSTRETH: rd_val_s = minstret_s[63:32];
      default: begin
        rd_val_s = '0;
        impl_s   = 1'b0;
      end
    endcase
    case (bus.csr_op)
      2'b01:   csr_new_s = bus.csr_wdata;
      2'b10:   csr_new_s = rd_val_s | bus.csr_wdata;
      2'b11:   csr_new_s = rd_val_s & ~bus.csr_wdata;
      default: csr_new_s = rd_val_s;
    endcase
  end

  assign op_s      = (bus.csr_op != 2'b00);
  assign act_s     = (state_q == ST_RUN) & bus.inst_valid;
  assign illegal_s = act_s & op_s & ~impl_s;
  assign exc_s     = act_s & bus.exc_valid;
  assign irq_s     = act_s & (|pend_s) & mstatus_mie_q;
  assign trap_s    = illegal_s | exc_s | irq_s;
  assign mret_s    = act_s & bus.is_mret & ~trap_s;
  assign csr_we_s  = act_s & op_s & ~trap_s;
  assign mtvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};

  // Trap cause selection and redirect target.
  always_comb begin
    trap_cause_s = 5'd0;
    trap_irq_s   = 1'b0;
    trap_tval_s  = '0;
    if (illegal_s) begin
      trap_cause_s = 5'd2;
    end else if (exc_s) begin
      trap_cause_s = {1'b0, bus.exc_cause};
      trap_tval_s  = bus.exc_tval;
    end else if (irq_s) begin
      trap_cause_s = irq_cause(pend_s);
      trap_irq_s   = 1'b1;
    end else begin
      trap_cause_s = 5'd0;
    end
    if (trap_s) begin
      if (trap_irq_s && (mtvec_q[1:0] == 2'b01)) begin
        bus.redirect_pc = mtvec_base_s + {25'd0, trap_cause_s, 2'b00};
      end else begin
        bus.redirect_pc = mtvec_base_s;
      end
    end else if (mret_s) begin
      bus.redirect_pc = mepc_q;
    end else begin
      bus.redirect_pc = '0;
    end
  end

  assign bus.csr_rdata      = op_s ? rd_val_s : '0;
  assign bus.trap_taken     = trap_s;
  assign bus.redirect_valid = trap_s | mret_s;
  assign bus.stall          = (state_q == ST_WAIT);

  // CSR next-state and WFI transitions; a trap masks both the CSR write and mret.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_s) begin
      mepc_d         = {bus.pc[XLEN-1:2], 2'b00};
      mcause_d       = {trap_irq_s, 26'd0, trap_cause_s};
      mtval_d        = trap_tval_s;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_s) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = csr_new_s[3];
          mstatus_mpie_d = csr_new_s[7];
        end
        A_MIE:    mie_d    = csr_new_s & MIE_MASK;
        A_MTVEC:  mtvec_d  = {csr_new_s[XLEN-1:2], (csr_new_s[1:0] == 2'b01) ? 2'b01 : 2'b00};
        A_MEPC:   mepc_d   = {csr_new_s[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause_d = csr_new_s;
        A_MTVAL:  mtval_d  = csr_new_s;
        default:  mtval_d  = mtval_q;
      endcase
    end else begin
      mtval_d = mtval_q;
    end
    case (state_q)
      ST_RUN:  state_d = (act_s & bus.is_wfi & ~trap_s) ? ST_WAIT : ST_RUN;
      ST_WAIT: state_d = (|pend_s) ? ST_RUN : ST_WAIT;
      default: state_d = ST_RUN;
    endcase
  end

  // CSR and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // Counter increment; a CSR write to one half replaces that half's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + ((act_s & ~trap_s) ? 64'd1 : 64'd0);
    if (csr_we_s) begin
      case (bus.csr_addr)
        A_MCYCLE:    mcycle_d[31:0]    = csr_new_s;
        A_MCYCLEH:   mcycle_d[63:32]   = csr_new_s;
        A_MINSTRET:  minstret_d[31:0]  = csr_new_s;
        A_MINSTRETH: minstret_d[63:32] = csr_new_s;
        default:     mcycle_d          = mcycle_q + 64'd1;
      endcase
    end else begin
      mcycle_d = mcycle_q + 64'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_s   = mcycle_q;
  assign minstret_s = minstret_q;
`else
  assign mcycle_s   = 64'd0;
  assign minstret_s = 64'd0;
`endif
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit (SYNC_STAGES=2, NUM_PLAT_IRQ=4).
module tb_csr_trap_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       irq_ext, irq_timer, irq_soft;
  logic [3:0] irq_plat;
  int         total = 0;
  int         bad = 0;

  csr_trap_unit_if #(.XLEN(32)) bus ();

  csr_trap_unit #(
    .XLEN(32), .NUM_PLAT_IRQ(4), .SYNC_STAGES(2), .MTVEC_RESET(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq_ext_i(irq_ext), .irq_timer_i(irq_timer),
    .irq_soft_i(irq_soft), .irq_plat_i(irq_plat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_addr = 12'h000; bus.csr_op = 2'b00; bus.csr_wdata = 32'h0;
    bus.inst_valid = 1'b0; bus.exc_valid = 1'b0; bus.exc_cause = 4'h0;
    bus.exc_tval = 32'h0; bus.is_mret = 1'b0; bus.is_wfi = 1'b0;
  endtask

  // One retiring CSR instruction.
  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    idle();
    bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d; bus.inst_valid = 1'b1;
    tick();
    idle();
  endtask

  // Non-retiring read (inst_valid low), consumes one cycle.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle();
    bus.csr_op = 2'b10; bus.csr_addr = a;
    #2;
    chk(tag, bus.csr_rdata, exp);
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.pc = 32'h0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; irq_plat = 4'h0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("rst_trap", bus.trap_taken, 32'h0);
    chk("rst_redir", bus.redirect_valid, 32'h0);
    chk("rst_stall", bus.stall, 32'h0);
    rd("rst_mie", 12'h304, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcause", 12'h342, 32'h0);

    // CSRRS / CSRRC on mstatus
    idle();
    bus.csr_op = 2'b10; bus.csr_addr = 12'h300; bus.csr_wdata = 32'h8; bus.inst_valid = 1'b1;
    #2;
    chk("rs_old", bus.csr_rdata, 32'h0000_1800);
    tick(); idle();
    rd("rs_new", 12'h300, 32'h0000_1808);
    csr(2'b11, 12'h300, 32'h8);
    rd("rc_new", 12'h300, 32'h0000_1800);

    // ecall with MIE=1; concurrent CSR write is dropped
    csr(2'b01, 12'h305, 32'h200);
    csr(2'b10, 12'h300, 32'h8);
    idle();
    bus.pc = 32'h100; bus.inst_valid = 1'b1; bus.exc_valid = 1'b1;
    bus.exc_cause = 4'd11; bus.exc_tval = 32'h55;
    bus.csr_op = 2'b01; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h999;
    #2;
    chk("exc_trap", bus.trap_taken, 32'h1);
    chk("exc_rv", bus.redirect_valid, 32'h1);
    chk("exc_rpc", bus.redirect_pc, 32'h200);
    tick(); idle();
    rd("exc_mepc", 12'h341, 32'h100);
    rd("exc_mcause", 12'h342, 32'hB);
    rd("exc_mtval", 12'h343, 32'h55);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);
    rd("exc_mtvec", 12'h305, 32'h200);

    // Unimplemented CSR beats exc_valid
    idle();
    bus.pc = 32'h104; bus.inst_valid = 1'b1; bus.csr_op = 2'b01;
    bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'h1234;
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd3; bus.exc_tval = 32'h77;
    #2;
    chk("ill_trap", bus.trap_taken, 32'h1);
    chk("ill_rpc", bus.redirect_pc, 32'h200);
    tick(); idle();
    rd("ill_mcause", 12'h342, 32'h2);
    rd("ill_mtval", 12'h343, 32'h0);
    rd("ill_mepc", 12'h341, 32'h104);

    // WARL masks
    csr(2'b01, 12'h305, 32'h403);
    rd("mtvec_warl", 12'h305, 32'h400);
    csr(2'b01, 12'h341, 32'h123);
    rd("mepc_align", 12'h341, 32'h120);
    csr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd("mie_mask", 12'h304, 32'h000F_0888);
    csr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd("mstatus_mask", 12'h300, 32'h0000_1888);
    csr(2'b01, 12'h300, 32'h0);
    rd("mip_idle", 12'h344, 32'h0);

    // Timer interrupt, vectored mode, latency of two stages
    csr(2'b01, 12'h305, 32'h401);
    csr(2'b01, 12'h304, 32'h80);
    csr(2'b10, 12'h300, 32'h8);
    idle();
    bus.pc = 32'h300; bus.inst_valid = 1'b1; irq_timer = 1'b1;
    #2;
    chk("tmr_lat0", bus.trap_taken, 32'h0);
    tick();
    chk("tmr_lat1", bus.trap_taken, 32'h0);
    tick();
    chk("tmr_lat2", bus.trap_taken, 32'h1);
    chk("tmr_rpc", bus.redirect_pc, 32'h41C);
    tick(); idle();
    irq_timer = 1'b0;
    rd("tmr_mip", 12'h344, 32'h80);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mepc", 12'h341, 32'h300);
    rd("tmr_mstatus", 12'h300, 32'h0000_1880);

    // MEI beats platform 0; mret; then platform 0
    csr(2'b01, 12'h305, 32'h200);
    csr(2'b01, 12'h304, 32'h0001_0800);
    csr(2'b10, 12'h300, 32'h8);
    idle();
    bus.pc = 32'h500; bus.inst_valid = 1'b1; irq_ext = 1'b1; irq_plat = 4'b0001;
    tick(); tick();
    chk("mei_trap", bus.trap_taken, 32'h1);
    chk("mei_rpc", bus.redirect_pc, 32'h200);
    tick(); idle();
    irq_ext = 1'b0;
    rd("mei_mcause", 12'h342, 32'h8000_000B);
    rd("mei_mepc", 12'h341, 32'h500);
    tick();
    idle();
    bus.pc = 32'h200; bus.is_mret = 1'b1; bus.inst_valid = 1'b1;
    #2;
    chk("mret_rv", bus.redirect_valid, 32'h1);
    chk("mret_trap", bus.trap_taken, 32'h0);
    chk("mret_rpc", bus.redirect_pc, 32'h500);
    tick(); idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    idle();
    bus.pc = 32'h504; bus.inst_valid = 1'b1;
    #2;
    chk("plat_trap", bus.trap_taken, 32'h1);
    tick(); idle();
    irq_plat = 4'h0;
    rd("plat_mcause", 12'h342, 32'h8000_0010);
    rd("plat_mepc", 12'h341, 32'h504);
    rd("plat_mstatus", 12'h300, 32'h0000_1880);

    // WFI with MIE=0: wakes without trap, ignores exceptions and writes while waiting
    csr(2'b01, 12'h304, 32'h800);
    csr(2'b01, 12'h300, 32'h0);
    idle();
    bus.pc = 32'h600; bus.is_wfi = 1'b1; bus.inst_valid = 1'b1;
    #2;
    chk("wfi0_run", bus.stall, 32'h0);
    tick(); idle();
    bus.pc = 32'h604; bus.inst_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_cause = 4'd2;
    bus.csr_op = 2'b01; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h999;
    #2;
    chk("wfi0_stall", bus.stall, 32'h1);
    chk("wfi0_noexc", bus.trap_taken, 32'h0);
    tick();
    irq_ext = 1'b1;
    tick(); tick();
    chk("wfi0_sync", bus.stall, 32'h1);
    idle();
    bus.pc = 32'h604; bus.inst_valid = 1'b1;
    tick();
    chk("wfi0_wake", bus.stall, 32'h0);
    chk("wfi0_notrap", bus.trap_taken, 32'h0);
    idle();
    irq_ext = 1'b0;
    rd("wfi0_mtvec", 12'h305, 32'h200);
    tick(); tick();

    // WFI with MIE=1: trap in first RUN cycle, mepc = pc after wfi
    csr(2'b10, 12'h300, 32'h8);
    idle();
    bus.pc = 32'h700; bus.is_wfi = 1'b1; bus.inst_valid = 1'b1;
    tick(); idle();
    bus.pc = 32'h704; bus.inst_valid = 1'b1;
    irq_ext = 1'b1;
    tick(); tick();
    chk("wfi1_sync", bus.stall, 32'h1);
    chk("wfi1_notrap", bus.trap_taken, 32'h0);
    tick();
    chk("wfi1_wake", bus.stall, 32'h0);
    chk("wfi1_trap", bus.trap_taken, 32'h1);
    chk("wfi1_rpc", bus.redirect_pc, 32'h200);
    tick(); idle();
    irq_ext = 1'b0;
    rd("wfi1_mepc", 12'h341, 32'h704);
    rd("wfi1_mcause", 12'h342, 32'h8000_000B);
    tick();

    // Reset while waiting
    csr(2'b01, 12'h300, 32'h0);
    idle();
    bus.pc = 32'h800; bus.is_wfi = 1'b1; bus.inst_valid = 1'b1;
    tick(); idle();
    chk("wfir_stall", bus.stall, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("wfir_run", bus.stall, 32'h0);

`ifdef CSR_COUNTERS_EN
    csr(2'b01, 12'hB80, 32'h5);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd("mcyc_lo_set", 12'hB00, 32'hFFFF_FFFF);
    rd("mcyc_hi_carry", 12'hB80, 32'h6);
    csr(2'b01, 12'hB02, 32'h10);
    rd("minstret_set", 12'hB02, 32'h10);
`else
    idle();
    bus.inst_valid = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = 12'hB00; bus.csr_wdata = 32'h5;
    #2;
    chk("ctr_off_legal", bus.trap_taken, 32'h0);
    chk("ctr_off_rd", bus.csr_rdata, 32'h0);
    tick(); idle();
    rd("ctr_off_rd2", 12'hB00, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
